// File: rtl/sha256_axi_v1_0_s00_axi.sv
// AXI4-Lite slave around a one-round-per-cycle SHA-256 compression engine.
// Software loads the IV via CTRL, streams 16 message words into DATA and
// reads the chained digest back from 0x20..0x3C. Padding is done in software.
//
// Handshake rules: a write is accepted when AWVALID and WVALID are both high,
// no response is pending, and AWREADY/WREADY (pulsed together for one cycle)
// are high. BVALID follows on the next cycle and holds until BREADY. A read is
// accepted on the ARREADY pulse; RVALID follows next cycle and RDATA stays
// stable until RREADY.
module sha256_axi_v1_0_s00_axi #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [3:0] REG_CTRL  = 4'd0;
    localparam logic [3:0] REG_DATA  = 4'd1;
    localparam logic [3:0] REG_COUNT = 4'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ROUND, ST_FINAL} state_t;

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    state_t      state;
    logic [31:0] h_reg [8];
    logic [31:0] wk [8];        // working registers a..h
    logic [31:0] w_win [16];    // message buffer, then the schedule window
    logic [5:0]  rnd;
    logic [3:0]  word_cnt;
    logic        done_r;
    logic        done_since_init;
    logic        busy;

    logic [3:0]  wr_idx;
    logic [3:0]  ar_idx;
    logic        wr_fire;
    logic        init_req;
    logic        data_req;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] w_new;
    logic [31:0] rd_mux;

    logic        unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign busy     = (state != ST_IDLE);
    assign wr_idx   = S_AXI_AWADDR[5:2];
    assign ar_idx   = S_AXI_ARADDR[5:2];
    assign wr_fire  = S_AXI_AWREADY && S_AXI_WREADY && S_AXI_AWVALID && S_AXI_WVALID;
    assign init_req = wr_fire && (wr_idx == REG_CTRL) && S_AXI_WDATA[0];
    assign data_req = wr_fire && (wr_idx == REG_DATA);
    assign S_AXI_RRESP = 2'b00;

    // One SHA-256 round plus the next schedule word from the sliding window.
    always_comb begin
        t1 = wk[7] + big_sigma1(wk[4]) + ((wk[4] & wk[5]) ^ (~wk[4] & wk[6]))
             + K[rnd] + w_win[0];
        t2 = big_sigma0(wk[0]) + ((wk[0] & wk[1]) ^ (wk[0] & wk[2]) ^ (wk[1] & wk[2]));
        w_new = small_sigma1(w_win[14]) + w_win[9] + small_sigma0(w_win[1]) + w_win[0];
    end

    // Register read multiplexer; unmapped and write-only offsets read as zero.
    always_comb begin
        rd_mux = '0;
        case (ar_idx)
            REG_CTRL:  rd_mux = {29'd0, done_since_init, done_r, busy};
            REG_COUNT: rd_mux = {28'd0, word_cnt};
            default:   if (ar_idx[3]) rd_mux = h_reg[ar_idx[2:0]];
        endcase
    end

    // Compression FSM: buffer words, load a..h, 64 rounds, fold into H.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state           <= ST_IDLE;
            rnd             <= '0;
            word_cnt        <= '0;
            done_r          <= 1'b0;
            done_since_init <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                h_reg[i] <= IV[i];
                wk[i]    <= '0;
            end
            for (int i = 0; i < 16; i++) w_win[i] <= '0;
        end else if (init_req) begin
            // INIT wins over everything, including a compression in flight.
            state           <= ST_IDLE;
            rnd             <= '0;
            word_cnt        <= '0;
            done_r          <= 1'b0;
            done_since_init <= 1'b0;
            for (int i = 0; i < 8; i++) h_reg[i] <= IV[i];
        end else begin
            case (state)
                ST_IDLE: begin
                    if (data_req) begin
                        w_win[word_cnt] <= S_AXI_WDATA;
                        word_cnt        <= word_cnt + 4'd1;   // wraps 15 -> 0
                        if (word_cnt == 4'd15) begin
                            state  <= ST_LOAD;
                            done_r <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    for (int i = 0; i < 8; i++) wk[i] <= h_reg[i];
                    rnd   <= '0;
                    state <= ST_ROUND;
                end
                ST_ROUND: begin
                    wk[0] <= t1 + t2;
                    wk[1] <= wk[0];
                    wk[2] <= wk[1];
                    wk[3] <= wk[2];
                    wk[4] <= wk[3] + t1;
                    wk[5] <= wk[4];
                    wk[6] <= wk[5];
                    wk[7] <= wk[6];
                    for (int i = 0; i < 15; i++) w_win[i] <= w_win[i+1];
                    w_win[15] <= w_new;
                    rnd       <= rnd + 6'd1;
                    if (rnd == 6'd63) state <= ST_FINAL;
                end
                ST_FINAL: begin
                    for (int i = 0; i < 8; i++) h_reg[i] <= h_reg[i] + wk[i];
                    done_r          <= 1'b1;
                    done_since_init <= 1'b1;
                    state           <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Write channel: single-cycle AW/W ready pulse, then a held response.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
        end else begin
            if (!S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID) begin
                S_AXI_AWREADY <= 1'b1;
                S_AXI_WREADY  <= 1'b1;
            end else begin
                S_AXI_AWREADY <= 1'b0;
                S_AXI_WREADY  <= 1'b0;
            end
            if (wr_fire) begin
                S_AXI_BVALID <= 1'b1;
                // A message word arriving while the engine runs is dropped.
                S_AXI_BRESP  <= (data_req && busy) ? 2'b10 : 2'b00;
            end else if (S_AXI_BVALID && S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
        end
    end

    // Read channel: single-cycle AR ready pulse, data captured and held.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            if (!S_AXI_ARREADY && S_AXI_ARVALID && !S_AXI_RVALID) S_AXI_ARREADY <= 1'b1;
            else S_AXI_ARREADY <= 1'b0;
            if (S_AXI_ARREADY && S_AXI_ARVALID) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_mux;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha256_axi_v1_0_s00_axi.sv
// Self-checking bench for the SHA-256 AXI4-Lite slave: known vectors,
// random blocks against a plain SHA-256 model, bus timing and error cases.
`timescale 1ns/1ps
module tb_sha256_axi_v1_0_s00_axi;

    typedef logic [7:0][31:0]  hash_t;
    typedef logic [15:0][31:0] block_t;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // ---------------- clock / reset and DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [5:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    always #5 clk = ~clk;

    sha256_axi_v1_0_s00_axi #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
        .S_AXI_ACLK(clk),       .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr),  .S_AXI_AWPROT(awprot),  .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata),    .S_AXI_WSTRB(wstrb),    .S_AXI_WVALID(wvalid),   .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp),    .S_AXI_BVALID(bvalid),  .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr),  .S_AXI_ARPROT(arprot),  .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata),    .S_AXI_RRESP(rresp),    .S_AXI_RVALID(rvalid),   .S_AXI_RREADY(rready)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q [$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic hash_t sha_compress(input hash_t hin, input block_t blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, s0, s1, ch, mj, tmp1, tmp2;
        hash_t hout;
        for (int t = 0; t < 16; t++) w[t] = blk[t];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        a = hin[0]; b = hin[1]; c = hin[2]; d = hin[3];
        e = hin[4]; f = hin[5]; g = hin[6]; h = hin[7];
        for (int t = 0; t < 64; t++) begin
            s1   = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
            ch   = (e & f) ^ (~e & g);
            tmp1 = h + s1 + ch + K_TAB[t] + w[t];
            s0   = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
            mj   = (a & b) ^ (a & c) ^ (b & c);
            tmp2 = s0 + mj;
            h = g; g = f; f = e; e = d + tmp1;
            d = c; c = b; b = a; a = tmp1 + tmp2;
        end
        hout[0] = hin[0] + a; hout[1] = hin[1] + b; hout[2] = hin[2] + c; hout[3] = hin[3] + d;
        hout[4] = hin[4] + e; hout[5] = hin[5] + f; hout[6] = hin[6] + g; hout[7] = hin[7] + h;
        return hout;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [1:0] exp_resp);
        int n;
        @(posedge clk); #1;
        awaddr  = addr | 6'($urandom_range(0, 3));
        awprot  = 3'($urandom_range(0, 7));
        wstrb   = 4'($urandom_range(0, 15));
        wdata   = data;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("wr_ready_within_4", 32'(n <= 4), 32'd1);
        if (!(awready && wready)) begin
            awvalid = 1'b0;
            wvalid  = 1'b0;
            return;
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check_eq("bvalid_next_cycle", 32'(bvalid), 32'd1);
        check_eq("bresp", 32'(bresp), 32'(exp_resp));
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data);
        int n;
        int hold;
        @(posedge clk); #1;
        araddr  = addr | 6'($urandom_range(0, 3));
        arprot  = 3'($urandom_range(0, 7));
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("ar_ready_seen", 32'(arready), 32'd1);
        data = 32'hxxxxxxxx;
        if (!arready) begin
            arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        check_eq("rvalid_next_cycle", 32'(rvalid), 32'd1);
        check_eq("rresp", 32'(rresp), 32'd0);
        data = rdata;
        hold = $urandom_range(0, 2);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("rdata_stable", rdata, data);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [5:0] addr, input logic [31:0] exp);
        logic [31:0] got;
        axi_read(addr, got);
        check_eq(tag, got, exp);
    endtask

    task automatic write_block(input block_t blk);
        for (int i = 0; i < 16; i++) axi_write(6'h04, blk[i], 2'b00);
    endtask

    task automatic expect_digest(input string tag, input hash_t d);
        logic [31:0] got;
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        for (int i = 0; i < 8; i++) begin
            axi_read(6'h20 + 6'(4 * i), got);
            check_eq(tag, got, exp_q.pop_front());
        end
    endtask

    function automatic block_t rand_block();
        block_t b;
        for (int i = 0; i < 16; i++) b[i] = $urandom;
        return b;
    endfunction

    // Random harmless traffic between message words.
    task automatic side_op(input int words_so_far);
        int r;
        r = $urandom_range(0, 4);
        case (r)
            0: axi_write(6'h0C + 6'(4 * $urandom_range(0, 4)), $urandom, 2'b00);
            1: axi_write(6'h20 + 6'(4 * $urandom_range(0, 7)), $urandom, 2'b00);
            2: read_check("reserved_or_data_reads_0",
                          ($urandom_range(0, 1) != 0) ? 6'h04 : 6'h0C + 6'(4 * $urandom_range(0, 4)), 32'd0);
            3: axi_write(6'h00, $urandom & 32'hffff_fffe, 2'b00);
            default: read_check("count_mid_block", 6'h08, 32'(words_so_far));
        endcase
    endtask

    // ---------------- test sequence ----------------
    initial begin
        hash_t  iv_h, abc_dig, two_dig, h_model, mid;
        block_t blk, blk2;
        int     n;

        iv_h[0] = 32'h6a09e667; iv_h[1] = 32'hbb67ae85; iv_h[2] = 32'h3c6ef372; iv_h[3] = 32'ha54ff53a;
        iv_h[4] = 32'h510e527f; iv_h[5] = 32'h9b05688c; iv_h[6] = 32'h1f83d9ab; iv_h[7] = 32'h5be0cd19;
        abc_dig[0] = 32'hba7816bf; abc_dig[1] = 32'h8f01cfea; abc_dig[2] = 32'h414140de; abc_dig[3] = 32'h5dae2223;
        abc_dig[4] = 32'hb00361a3; abc_dig[5] = 32'h96177a9c; abc_dig[6] = 32'hb410ff61; abc_dig[7] = 32'hf20015ad;
        two_dig[0] = 32'h248d6a61; two_dig[1] = 32'hd20638b8; two_dig[2] = 32'he5c02693; two_dig[3] = 32'h0c3e6039;
        two_dig[4] = 32'ha33ce459; two_dig[5] = 32'h64ff2167; two_dig[6] = 32'hf6ecedd4; two_dig[7] = 32'h19db06c1;

        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_awready", 32'(awready), 32'd0);
        check_eq("rst_wready",  32'(wready),  32'd0);
        check_eq("rst_bvalid",  32'(bvalid),  32'd0);
        check_eq("rst_bresp",   32'(bresp),   32'd0);
        check_eq("rst_arready", 32'(arready), 32'd0);
        check_eq("rst_rvalid",  32'(rvalid),  32'd0);
        check_eq("rst_rdata",   rdata,        32'd0);
        check_eq("rst_rresp",   32'(rresp),   32'd0);
        rst = 1'b0;
        expect_digest("reset_iv", iv_h);
        read_check("reset_ctrl", 6'h00, 32'd0);
        read_check("reset_count", 6'h08, 32'd0);

        // "abc" single block; done must be visible 66 cycles after the last word.
        axi_write(6'h00, 32'h1, 2'b00);
        blk = '0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        write_block(blk);
        repeat (63) @(posedge clk);
        read_check("abc_ctrl_done", 6'h00, 32'd6);
        expect_digest("abc_digest", abc_dig);

        // Two-block 448-bit message, with reads during the second compression.
        axi_write(6'h00, 32'h1, 2'b00);
        blk = '0;
        blk[0]  = 32'h61626364; blk[1]  = 32'h62636465; blk[2]  = 32'h63646566; blk[3]  = 32'h64656667;
        blk[4]  = 32'h65666768; blk[5]  = 32'h66676869; blk[6]  = 32'h6768696a; blk[7]  = 32'h68696a6b;
        blk[8]  = 32'h696a6b6c; blk[9]  = 32'h6a6b6c6d; blk[10] = 32'h6b6c6d6e; blk[11] = 32'h6c6d6e6f;
        blk[12] = 32'h6d6e6f70; blk[13] = 32'h6e6f7071; blk[14] = 32'h80000000; blk[15] = 32'h00000000;
        blk2 = '0;
        blk2[15] = 32'h000001c0;
        mid = sha_compress(iv_h, blk);
        write_block(blk);
        repeat (70) @(posedge clk);
        expect_digest("two_block_mid", mid);
        write_block(blk2);
        read_check("two_block_ctrl_busy", 6'h00, 32'd5);
        read_check("two_block_h0_during_busy", 6'h20, mid[0]);
        repeat (70) @(posedge clk);
        expect_digest("two_block_digest", two_dig);

        // DATA write while busy is dropped with SLVERR.
        axi_write(6'h00, 32'h1, 2'b00);
        blk = rand_block();
        write_block(blk);
        axi_write(6'h04, $urandom, 2'b10);
        read_check("busy_write_count", 6'h08, 32'd0);
        repeat (70) @(posedge clk);
        h_model = sha_compress(iv_h, blk);
        expect_digest("busy_write_digest", h_model);

        // Partial block then INIT: count clears and H returns to the IV.
        for (int i = 0; i < 5; i++) axi_write(6'h04, $urandom, 2'b00);
        read_check("partial_count", 6'h08, 32'd5);
        axi_write(6'h00, 32'h1, 2'b00);
        read_check("init_count", 6'h08, 32'd0);
        read_check("init_ctrl", 6'h00, 32'd0);
        expect_digest("init_iv", iv_h);

        // INIT during compression aborts it; the next block starts clean.
        blk = rand_block();
        write_block(blk);
        axi_write(6'h00, 32'h1, 2'b00);
        read_check("abort_ctrl", 6'h00, 32'd0);
        repeat (70) @(posedge clk);
        expect_digest("abort_iv", iv_h);
        blk = rand_block();
        write_block(blk);
        repeat (70) @(posedge clk);
        expect_digest("after_abort_digest", sha_compress(iv_h, blk));

        // Random chained blocks with interleaved ignored traffic.
        axi_write(6'h00, 32'h1, 2'b00);
        h_model = iv_h;
        for (int b = 0; b < 3; b++) begin
            blk = rand_block();
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 3) == 0) side_op(i);
                axi_write(6'h04, blk[i], 2'b00);
            end
            repeat (70) @(posedge clk);
            h_model = sha_compress(h_model, blk);
            expect_digest("chain_digest", h_model);
        end

        // Asynchronous reset in the middle of a compression with a response pending.
        blk = rand_block();
        write_block(blk);
        repeat (20) @(posedge clk);
        #1;
        awaddr = 6'h08; wdata = $urandom; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        while (!awready && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check_eq("pre_reset_bvalid", 32'(bvalid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_reset_bvalid", 32'(bvalid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        read_check("post_reset_ctrl", 6'h00, 32'd0);
        read_check("post_reset_count", 6'h08, 32'd0);
        expect_digest("post_reset_iv", iv_h);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
